// File: rtl/audio_pkg.sv
// Shared audio capture types and defaults, also used by the waveform store.
package audio_pkg;

  localparam int SAMPLE_W_DEF   = 24;
  localparam int SLOT_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int CNT_W          = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } fsm_t;

  typedef struct packed {
    logic [SAMPLE_W_DEF-1:0] left;
    logic [SAMPLE_W_DEF-1:0] right;
  } stereo_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock show-ahead FIFO holding stereo pairs; a pop frees room for a same-cycle push when full.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign level = level_q;
  // Head is forced to zero when empty so stale entries never appear on the bus.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
    else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/i2s_rx_capture.sv
// I2S receiver: synchronizes the codec stream, assembles {left,right} pairs and
// queues them on a valid/ready stream for the waveform store.
module i2s_rx_capture
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int SLOT_W     = SLOT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          i2s_bclk,
  input  logic                          i2s_lrclk,
  input  logic                          i2s_sdata,
  output logic [2*SAMPLE_W-1:0]         sample_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          frame_err,
  output logic [1:0]                    dbg_state
);

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SLOT_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_W);

  logic [1:0]            bclk_sync_q, bclk_sync_d;
  logic [1:0]            lr_sync_q, lr_sync_d;
  logic [1:0]            sd_sync_q, sd_sync_d;
  logic                  bclk_last_q, bclk_last_d;
  logic                  lr_prev_q, lr_prev_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0]   shift_q, shift_d;
  logic [SAMPLE_W-1:0]   left_q, left_d;
  logic [2*SAMPLE_W-1:0] pair_q, pair_d;
  logic                  push_q, push_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overflow_q, overflow_d;
  fsm_t                  state_q, state_d;

  logic rise, lr_s, sd_s, lr_chg, pop, fifo_full, fifo_empty;

  // Stream handshake: a pair transfers on any clk edge where sample_valid and
  // sample_ready are both high; valid depends only on registered FIFO state.
  assign sample_valid = ~fifo_empty;
  assign pop          = sample_valid & sample_ready;
  assign overflow     = overflow_q;
  assign frame_err    = frame_err_q;
  assign dbg_state    = state_q;

  assign rise   = bclk_sync_q[1] & ~bclk_last_q;
  assign lr_s   = lr_sync_q[1];
  assign sd_s   = sd_sync_q[1];
  assign lr_chg = rise & (lr_s != lr_prev_q);

  always_comb begin
    bclk_sync_d = {bclk_sync_q[0], i2s_bclk};
    lr_sync_d   = {lr_sync_q[0], i2s_lrclk};
    sd_sync_d   = {sd_sync_q[0], i2s_sdata};
    bclk_last_d = bclk_sync_q[1];
    lr_prev_d   = lr_prev_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    left_d      = left_q;
    pair_d      = pair_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    state_d     = state_q;

    // The lrclk-change rise is the discarded delay bit; the next SAMPLE_W rises carry data.
    if (rise) begin
      lr_prev_d = lr_s;
      if (lr_chg) begin
        bit_cnt_d = '0;
        shift_d   = '0;
      end else begin
        if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q < CNT_FULL) shift_d = {shift_q[SAMPLE_W-2:0], sd_s};
      end
    end

    case (state_q)
      IDLE: begin
        if (lr_chg && !lr_s) state_d = LEFT;
      end
      LEFT: begin
        if (lr_chg) begin
          if (bit_cnt_q >= CNT_FULL) begin
            left_d  = shift_q;
            state_d = RIGHT;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end else if (rise && bit_cnt_q == CNT_LAST) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      RIGHT: begin
        if (lr_chg) begin
          // The 1->0 edge that closes the pair also opens the next left slot.
          state_d = LEFT;
          if (bit_cnt_q >= CNT_FULL) begin
            pair_d = {left_q, shift_q};
            push_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (rise && bit_cnt_q == CNT_LAST) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d     = IDLE;
      push_d      = 1'b0;
      frame_err_d = 1'b0;
    end

    overflow_d = (overflow_q & ~overflow_clr) | (push_q & fifo_full & ~pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      bclk_last_q <= 1'b0;
      lr_prev_q   <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      left_q      <= '0;
      pair_q      <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      state_q     <= IDLE;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      sd_sync_q   <= sd_sync_d;
      bclk_last_q <= bclk_last_d;
      lr_prev_q   <= lr_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      left_q      <= left_d;
      pair_q      <= pair_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push_q),
    .pop   (pop),
    .wdata (pair_q),
    .rdata (sample_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Bench for i2s_rx_capture: slot-level I2S driver, slot-level reference model, scoreboard monitor.
module tb_i2s_rx_capture;
  import audio_pkg::*;

  localparam int SW    = 24;
  localparam int SLOT  = 32;
  localparam int DEPTH = 16;
  localparam int HALF  = 8;
  localparam int PW    = 2*SW;

  logic          clk          = 1'b0;
  logic          rst          = 1'b1;
  logic          en           = 1'b1;
  logic          i2s_bclk     = 1'b0;
  logic          i2s_lrclk    = 1'b0;
  logic          i2s_sdata    = 1'b0;
  logic          sample_ready = 1'b0;
  logic          overflow_clr = 1'b0;
  logic [PW-1:0] sample_data;
  logic          sample_valid;
  logic [4:0]    fifo_level;
  logic          overflow;
  logic          frame_err;
  logic [1:0]    dbg_state;

  always #10 clk = ~clk;

  i2s_rx_capture #(.SAMPLE_W(SW), .SLOT_W(SLOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .frame_err    (frame_err),
    .dbg_state    (dbg_state)
  );

  int total = 0;
  int bad = 0;
  int pops = 0;
  int err_seen = 0;
  int exp_err = 0;
  logic [PW-1:0] exp_q[$];

  // Slot-level reference model
  logic          m_lr = 1'b0;
  bit            m_synced = 1'b0;
  int            m_len = 0;
  logic [SW-1:0] m_data = '0;
  logic [SW-1:0] m_left = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        if (frame_err) err_seen++;
        if (sample_valid && sample_ready) begin
          pops++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got %0h expected none", sample_data);
          end else begin
            check("pop_data", 64'(sample_data), 64'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic model_push(input logic [PW-1:0] p, input bit pop_same);
    if (exp_q.size() >= DEPTH && !pop_same) begin
      // dropped pair; overflow checked by the bench at phase ends
    end else begin
      exp_q.push_back(p);
    end
  endtask

  task automatic model_start(input logic lr, input bit pop_same);
    if (lr != m_lr) begin
      if (m_synced) begin
        if (m_len - 1 < SW) begin
          exp_err++;
          if (m_lr == 1'b0) m_synced = 1'b0;
        end else if (m_lr == 1'b0) begin
          m_left = m_data;
        end else begin
          model_push({m_left, m_data}, pop_same);
        end
      end
      m_len = 0;
      m_lr  = lr;
      if (lr == 1'b0) m_synced = en;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_lr = 1'b0;
    m_len = 0;
    m_synced = 1'b0;
  endtask

  task automatic send_bit(input logic lr, input logic d, input bit pulse);
    @(negedge clk);
    i2s_lrclk = lr;
    i2s_sdata = d;
    repeat (HALF-1) @(negedge clk);
    i2s_bclk = 1'b1;
    if (pulse) begin
      repeat (3) @(negedge clk);
      sample_ready = 1'b1;
      @(negedge clk);
      sample_ready = 1'b0;
      repeat (HALF-4) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    i2s_bclk = 1'b0;
  endtask

  task automatic send_slot(input logic lr, input int n, input logic [SW-1:0] data, input bit pulse);
    model_start(lr, pulse);
    for (int i = 0; i < n; i++) begin
      logic d;
      if (i >= 1 && i <= SW) d = data[SW-i];
      else d = 1'($urandom_range(0, 1));
      send_bit(lr, d, pulse && (i == 0));
      m_len++;
      if (m_synced && (m_len - 1 > SLOT)) begin
        exp_err++;
        m_synced = 1'b0;
      end
    end
    m_data = data;
  endtask

  task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
    send_slot(1'b0, SLOT, l, 1'b0);
    send_slot(1'b1, SLOT, r, 1'b0);
  endtask

  function automatic logic [SW-1:0] rnd24();
    return SW'($urandom);
  endfunction

  task automatic drain(input string name, input int n_exp);
    int p0;
    int n;
    p0 = pops;
    n = 0;
    @(negedge clk);
    sample_ready = 1'b1;
    while (sample_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    check({name, "_pops"}, 64'(pops - p0), 64'(n_exp));
    check({name, "_valid"}, 64'(sample_valid), 64'(0));
    check({name, "_level"}, 64'(fifo_level), 64'(0));
  endtask

  initial begin
    int e0;
    #5 rst = 1'b0;
    for (int i = 0; i < 6; i++) send_bit(1'(i % 2), 1'($urandom_range(0, 1)), 1'b0);
    i2s_lrclk = 1'b0;
    #1;
    check("rst_valid", 64'(sample_valid), 64'(0));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_data", 64'(sample_data), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_frame_err", 64'(frame_err), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Known pattern, first frame only syncs
    sample_ready = 1'b0;
    for (int f = 0; f < 3; f++) send_frame(24'h123456, 24'hABCDEF);
    send_slot(1'b0, SLOT, 24'h123456, 1'b0);
    check("t1_level", 64'(fifo_level), 64'(2));
    check("t1_valid", 64'(sample_valid), 64'(1));
    check("t1_head", 64'(sample_data), 64'(48'h123456_ABCDEF));
    send_slot(1'b1, SLOT, 24'hABCDEF, 1'b0);
    drain("t1_drain", 2);

    // Backpressure and overflow
    sample_ready = 1'b0;
    for (int f = 0; f < 20; f++) send_frame(rnd24(), rnd24());
    check("bp_level", 64'(fifo_level), 64'(16));
    check("bp_overflow", 64'(overflow), 64'(1));
    @(negedge clk);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    #1;
    check("bp_ovf_clr", 64'(overflow), 64'(0));

    // Full FIFO with pop on the push cycle
    send_slot(1'b0, SLOT, rnd24(), 1'b1);
    check("full_pp_level", 64'(fifo_level), 64'(16));
    check("full_pp_overflow", 64'(overflow), 64'(0));
    send_slot(1'b1, SLOT, rnd24(), 1'b0);
    drain("bp_drain", 16);

    // Short left slot
    sample_ready = 1'b1;
    e0 = err_seen;
    send_slot(1'b0, 11, rnd24(), 1'b0);
    send_slot(1'b1, SLOT, rnd24(), 1'b0);
    check("short_err", 64'(err_seen - e0), 64'(1));
    send_frame(rnd24(), rnd24());
    send_frame(rnd24(), rnd24());
    check("short_pending", 64'(exp_q.size()), 64'(0));

    // Stuck lrclk
    e0 = err_seen;
    send_slot(1'b0, 33, rnd24(), 1'b0);
    check("stuck_no_err_yet", 64'(err_seen - e0), 64'(0));
    check("stuck_state_left", 64'(dbg_state), 64'(1));
    send_slot(1'b0, 7, rnd24(), 1'b0);
    check("stuck_err", 64'(err_seen - e0), 64'(1));
    check("stuck_state_idle", 64'(dbg_state), 64'(0));
    send_slot(1'b1, SLOT, rnd24(), 1'b0);
    send_frame(rnd24(), rnd24());
    send_frame(rnd24(), rnd24());
    check("stuck_pending", 64'(exp_q.size()), 64'(0));

    // en dropped mid right slot
    sample_ready = 1'b0;
    send_slot(1'b0, SLOT, rnd24(), 1'b0);
    send_slot(1'b1, 12, rnd24(), 1'b0);
    @(negedge clk);
    en = 1'b0;
    m_synced = 1'b0;
    send_slot(1'b1, 20, rnd24(), 1'b0);
    send_slot(1'b0, SLOT, rnd24(), 1'b0);
    @(negedge clk);
    en = 1'b1;
    send_slot(1'b1, SLOT, rnd24(), 1'b0);
    send_frame(rnd24(), rnd24());
    check("en_level", 64'(fifo_level), 64'(1));
    check("en_head", 64'(sample_data), 64'(exp_q[0]));
    drain("en_drain", 1);

    // Async reset mid slot
    sample_ready = 1'b0;
    send_slot(1'b0, SLOT, rnd24(), 1'b0);
    check("prerst_level", 64'(fifo_level), 64'(1));
    send_slot(1'b1, 10, rnd24(), 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("midrst_level", 64'(fifo_level), 64'(0));
    check("midrst_valid", 64'(sample_valid), 64'(0));
    check("midrst_data", 64'(sample_data), 64'(0));
    check("midrst_state", 64'(dbg_state), 64'(0));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    send_slot(1'b1, 22, rnd24(), 1'b0);
    send_frame(rnd24(), rnd24());
    send_frame(rnd24(), rnd24());
    drain("rst_drain", 1);

    check("err_total", 64'(err_seen), 64'(exp_err));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
